fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 109 ++++++++++
 tb/tb_fifo_reader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: drains a show-ahead FIFO into a ready/valid stream.
// It has a two-entry output buffer: a head register that drives the stream
// and a skid register that absorbs the pop already in flight when the
// downstream stalls. The FIFO pop strobe never depends on OUT_READY.
// Optional feature: define FIFO_READER_COUNT_EN to add a 16-bit WORD_COUNT
// output that counts delivered words.
module fifo_reader #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic                  FLUSH,
    input  logic [DATA_WIDTH-1:0] FIFO_DATA,
    input  logic                  FIFO_EMPTY,
    output logic                  FIFO_POP,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY
`ifdef FIFO_READER_COUNT_EN
    ,
    output logic [15:0]           WORD_COUNT
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_skid;
    logic                  r_valid;

    logic                  w_pop;
    logic                  w_xfer;

    // The pop decision uses only registered occupancy and upstream inputs, so
    // a stalled downstream can never create a combinational path to the FIFO.
    // Only the full (TWO) state blocks a pop; ONE always has room in the skid.
    assign w_pop  = !RESET && ENABLE && !FLUSH && !FIFO_EMPTY && (r_state != ST_TWO);
    assign w_xfer = r_valid && OUT_READY;

    assign FIFO_POP  = w_pop;
    assign OUT_DATA  = r_head;
    assign OUT_VALID = r_valid;

    // Occupancy FSM: reset beats flush, flush beats any pop or transfer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
            r_head  <= '0;
            r_skid  <= '0;
        end else if (FLUSH) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_pop) begin
                        r_head  <= FIFO_DATA;
                        r_valid <= 1'b1;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_pop && w_xfer) begin
                        r_head  <= FIFO_DATA;
                    end else if (w_pop) begin
                        r_skid  <= FIFO_DATA;
                        r_state <= ST_TWO;
                    end else if (w_xfer) begin
                        r_valid <= 1'b0;
                        r_state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_xfer) begin
                        r_head  <= r_skid;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef FIFO_READER_COUNT_EN
    logic [15:0] r_word_count;

    assign WORD_COUNT = r_word_count;

    // Delivered-word counter; a transfer coinciding with a flush is discarded.
    always_ff @(posedge CLK) begin
        if (RESET || FLUSH) begin
            r_word_count <= 16'h0000;
        end else if (w_xfer) begin
            r_word_count <= r_word_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed bench for fifo_reader with a small show-ahead
// FIFO model. Define FIFO_READER_COUNT_EN to also exercise WORD_COUNT.
module tb_fifo_reader;

    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          ENABLE;
    logic          FLUSH;
    logic [DW-1:0] FIFO_DATA;
    logic          FIFO_EMPTY;
    logic          FIFO_POP;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY;
`ifdef FIFO_READER_COUNT_EN
    logic [15:0]   WORD_COUNT;
`endif

    int passCount = 0;
    int checkCount = 0;
    int rdPtr = 0;
    int wrPtr = 0;
    int popCount = 0;
    int snapPops;
    logic [31:0] mem [64];

    logic [31:0] streamWords [4] = '{32'hAAAA5555, 32'hBBBB6666, 32'hCCCC7777, 32'hDDDD8888};
    logic [31:0] bpWords [4]     = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    fifo_reader #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ENABLE     (ENABLE),
        .FLUSH      (FLUSH),
        .FIFO_DATA  (FIFO_DATA),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_POP   (FIFO_POP),
        .OUT_DATA   (OUT_DATA),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY)
`ifdef FIFO_READER_COUNT_EN
        ,
        .WORD_COUNT (WORD_COUNT)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    always #5 CLK = ~CLK;

    // Show-ahead FIFO model: head word is visible whenever not empty.
    assign FIFO_DATA  = mem[rdPtr[5:0]];
    assign FIFO_EMPTY = (rdPtr >= wrPtr);

    // The FIFO consumes its head on every edge where the DUT pops.
    always @(posedge CLK) begin
        if (FIFO_POP) begin
            rdPtr    <= rdPtr + 1;
            popCount <= popCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic fl, input logic rdy);
        RESET     = rst;
        ENABLE    = en;
        FLUSH     = fl;
        OUT_READY = rdy;
    endtask

    task automatic pushWord(input logic [31:0] w);
        mem[wrPtr[5:0]] = w;
        wrPtr++;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expectOutputs(input string tag, input logic expValid, input logic [31:0] expData,
                                 input logic expPop);
        #1;
        checkOutput({tag, ".valid"}, 32'(OUT_VALID), 32'(expValid));
        checkOutput({tag, ".pop"}, 32'(FIFO_POP), 32'(expPop));
        if (expValid) begin
            checkOutput({tag, ".data"}, OUT_DATA, expData);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) pushWord(streamWords[i]);

        // Reset held 20 cycles with a non-empty FIFO: nothing popped, outputs zero.
        for (int i = 0; i < 20; i++) begin
            tick();
            expectOutputs($sformatf("reset%0d", i), 1'b0, 32'h0, 1'b0);
            checkOutput($sformatf("reset%0d.data", i), OUT_DATA, 32'h0);
        end
        checkOutput("reset.pops", popCount, 0);

        // Streaming: release reset, one pop now, then one word per cycle.
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        expectOutputs("stream.start", 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            expectOutputs($sformatf("stream%0d", k), 1'b1, streamWords[k], k < 3);
        end
        tick();
        expectOutputs("stream.end", 1'b0, 32'h0, 1'b0);
        checkOutput("stream.pops", popCount, 4);

        // Backpressure: exactly two pops fill head and skid, then hold.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pushWord(bpWords[i]);
        snapPops = popCount;
        for (int i = 0; i < 5; i++) begin
            tick();
            expectOutputs($sformatf("bp.stall%0d", i), 1'b1, bpWords[0], i == 0);
        end
        checkOutput("bp.pops", popCount - snapPops, 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) begin
            tick();
            expectOutputs($sformatf("bp.drain%0d", j), 1'b1, bpWords[j+1], j < 2);
        end
        tick();
        expectOutputs("bp.end", 1'b0, 32'h0, 1'b0);

        // Flush with the buffer full and downstream ready.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        pushWord(32'h55555555);
        pushWord(32'h66666666);
        pushWord(32'h01234567);
        pushWord(32'h89ABCDEF);
        tick();
        expectOutputs("fl.one", 1'b1, 32'h55555555, 1'b1);
        tick();
        expectOutputs("fl.two", 1'b1, 32'h55555555, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        snapPops = popCount;
        expectOutputs("fl.pulse", 1'b1, 32'h55555555, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        expectOutputs("fl.after", 1'b0, 32'h0, 1'b1);
        checkOutput("fl.pops", popCount - snapPops, 0);
        tick();
        expectOutputs("fl.next0", 1'b1, 32'h01234567, 1'b1);
        tick();
        expectOutputs("fl.next1", 1'b1, 32'h89ABCDEF, 1'b0);
        tick();
        expectOutputs("fl.end", 1'b0, 32'h0, 1'b0);

        // Flush in ONE while the FIFO still has data: the pop must be suppressed.
        pushWord(32'hA1A1A1A1);
        pushWord(32'hA2A2A2A2);
        tick();
        expectOutputs("fl1.one", 1'b1, 32'hA1A1A1A1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        snapPops = popCount;
        expectOutputs("fl1.pulse", 1'b1, 32'hA1A1A1A1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        expectOutputs("fl1.after", 1'b0, 32'h0, 1'b1);
        checkOutput("fl1.pops", popCount - snapPops, 0);
        tick();
        expectOutputs("fl1.next", 1'b1, 32'hA2A2A2A2, 1'b0);
        tick();
        expectOutputs("fl1.end", 1'b0, 32'h0, 1'b0);

        // Enable low: the buffered word drains, no new pops until re-enabled.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        pushWord(32'hE1E1E1E1);
        pushWord(32'hE2E2E2E2);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectOutputs("en.hold", 1'b1, 32'hE1E1E1E1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expectOutputs($sformatf("en.off%0d", i), 1'b0, 32'h0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        expectOutputs("en.on", 1'b0, 32'h0, 1'b1);
        tick();
        expectOutputs("en.next", 1'b1, 32'hE2E2E2E2, 1'b0);
        tick();
        expectOutputs("en.end", 1'b0, 32'h0, 1'b0);

        // Reset mid-stream discards the buffered word without popping.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        pushWord(32'hC0C0C0C0);
        pushWord(32'hC1C1C1C1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        snapPops = popCount;
        expectOutputs("rst.mid", 1'b1, 32'hC0C0C0C0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        expectOutputs("rst.after", 1'b0, 32'h0, 1'b1);
        checkOutput("rst.after.data", OUT_DATA, 32'h0);
        checkOutput("rst.pops", popCount - snapPops, 0);
        tick();
        expectOutputs("rst.next", 1'b1, 32'hC1C1C1C1, 1'b0);
        tick();
        expectOutputs("rst.end", 1'b0, 32'h0, 1'b0);

`ifdef FIFO_READER_COUNT_EN
        // Counter: wrap from 0xFFFF to 0x0000, cleared by reset and flush.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        #1;
        checkOutput("cnt.reset", 32'(WORD_COUNT), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        wrPtr = rdPtr + 70000;
        tick();
        tick();
        #1;
        checkOutput("cnt.first", 32'(WORD_COUNT), 32'h1);
        repeat (65534) @(posedge CLK);
        #2;
        checkOutput("cnt.max", 32'(WORD_COUNT), 32'hFFFF);
        tick();
        #1;
        checkOutput("cnt.wrap", 32'(WORD_COUNT), 32'h0);
        tick();
        #1;
        checkOutput("cnt.after", 32'(WORD_COUNT), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        wrPtr = rdPtr;
        #1;
        checkOutput("cnt.flush", 32'(WORD_COUNT), 32'h0);
        tick();
        tick();
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
